// File: rtl/param_fwft_fifo.sv
// param_fwft_fifo: single-clock first-word-fall-through FIFO.
// depth = 2**DEPTH_WIDTH entries of DATA_WIDTH bits. All status outputs come
// from registered state, so a full FIFO never accepts a write in the same
// cycle as a read.
// Optional build macro PARAM_FWFT_FIFO_ERRFLAG_EN adds sticky overflow and
// underflow outputs that record dropped writes and dropped reads.
//
// Handshake: a write is accepted on a rising edge when wrreq=1 and wrfull=0.
// A read is accepted on a rising edge when rdreq=1 and rdempty=0. Requests
// that are not accepted are dropped and change nothing. q always shows the
// head entry while rdempty=0, and shows zero while rdempty=1.
module param_fwft_fifo #(
   parameter int unsigned DATA_WIDTH   = 256,
   parameter int unsigned DEPTH_WIDTH  = 4,
   parameter int unsigned AFULL_LEVEL  = 2**DEPTH_WIDTH - 1,
   parameter int unsigned AEMPTY_LEVEL = 1
) (
   input  logic                   clk,
   input  logic                   nRst,
   input  logic                   flush,
   input  logic [DATA_WIDTH-1:0]  data,
   input  logic                   wrreq,
   output logic                   wrfull,
   output logic                   walmostfull,
   input  logic                   rdreq,
   output logic [DATA_WIDTH-1:0]  q,
   output logic                   rdempty,
   output logic                   ralmostempty,
   output logic [DEPTH_WIDTH:0]   level
`ifdef PARAM_FWFT_FIFO_ERRFLAG_EN
   ,
   output logic                   overflow,
   output logic                   underflow
`endif
);

   localparam int unsigned DEPTH = 2**DEPTH_WIDTH;
   localparam logic [DEPTH_WIDTH:0] DEPTH_L  = (DEPTH_WIDTH+1)'(DEPTH);
   localparam logic [DEPTH_WIDTH:0] AFULL_L  = (DEPTH_WIDTH+1)'(AFULL_LEVEL);
   localparam logic [DEPTH_WIDTH:0] AEMPTY_L = (DEPTH_WIDTH+1)'(AEMPTY_LEVEL);

   // Storage is never cleared; level and pointers alone define validity.
   logic [DATA_WIDTH-1:0]  mem [DEPTH];

   logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_WIDTH:0]   level_q,  level_d;
   logic                   wr_en;
   logic                   rd_en;
   logic                   mem_we;

   // Status flags decoded from the registered level only.
   always_comb begin
      wrfull       = (level_q == DEPTH_L);
      rdempty      = (level_q == '0);
      walmostfull  = (level_q >= AFULL_L);
      ralmostempty = (level_q <= AEMPTY_L);
      level        = level_q;
      wr_en        = wrreq & ~wrfull;
      rd_en        = rdreq & ~rdempty;
      mem_we       = wr_en & nRst & ~flush;
      q            = rdempty ? '0 : mem[rd_ptr_q];
   end

   // Next-state for pointers and level; reset beats flush beats requests.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (!nRst || flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end
   end

   // Pointer and level registers.
   always_ff @(posedge clk) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
   end

   // Array write at the write pointer for each accepted write.
   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_ptr_q] <= data;
   end

`ifdef PARAM_FWFT_FIFO_ERRFLAG_EN
   logic overflow_q,  overflow_d;
   logic underflow_q, underflow_d;

   // Sticky error flags: set by dropped requests, cleared by reset or flush.
   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (!nRst || flush) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wrreq && wrfull)  overflow_d  = 1'b1;
         if (rdreq && rdempty) underflow_d = 1'b1;
      end
   end

   // Error flag registers.
   always_ff @(posedge clk) begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_param_fwft_fifo.sv
// Directed bench for param_fwft_fifo with 4 entries of 8 bits,
// almost-full at 3, almost-empty at 1.
module tb_param_fwft_fifo;

   localparam int DW = 8;
   localparam int AW = 2;

   logic          clk;
   logic          nRst;
   logic          flush;
   logic [DW-1:0] data;
   logic          wrreq;
   logic          wrfull;
   logic          walmostfull;
   logic          rdreq;
   logic [DW-1:0] q;
   logic          rdempty;
   logic          ralmostempty;
   logic [AW:0]   level;
`ifdef PARAM_FWFT_FIFO_ERRFLAG_EN
   logic          overflow;
   logic          underflow;
`endif

   int checks = 0;
   int errors = 0;

   param_fwft_fifo #(
      .DATA_WIDTH   (DW),
      .DEPTH_WIDTH  (AW),
      .AFULL_LEVEL  (3),
      .AEMPTY_LEVEL (1)
   ) dut (
      .clk          (clk),
      .nRst         (nRst),
      .flush        (flush),
      .data         (data),
      .wrreq        (wrreq),
      .wrfull       (wrfull),
      .walmostfull  (walmostfull),
      .rdreq        (rdreq),
      .q            (q),
      .rdempty      (rdempty),
      .ralmostempty (ralmostempty),
      .level        (level)
`ifdef PARAM_FWFT_FIFO_ERRFLAG_EN
      ,
      .overflow     (overflow),
      .underflow    (underflow)
`endif
   );

   // Clock and reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock with the given requests, then all requests drop.
   task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
      wrreq = w;
      data  = d;
      rdreq = r;
      flush = f;
      tick();
      wrreq = 1'b0;
      rdreq = 1'b0;
      flush = 1'b0;
      data  = '0;
   endtask

   // Check every status output against a hand-derived level and head value.
   task automatic chk_state(input string tag, input int lvl, input logic [DW-1:0] head);
      chk({tag, "_level"}, 32'(level), 32'(lvl));
      chk({tag, "_q"}, 32'(q), 32'(head));
      chk({tag, "_rdempty"}, 32'(rdempty), 32'(lvl == 0));
      chk({tag, "_wrfull"}, 32'(wrfull), 32'(lvl == 4));
      chk({tag, "_afull"}, 32'(walmostfull), 32'(lvl >= 3));
      chk({tag, "_aempty"}, 32'(ralmostempty), 32'(lvl <= 1));
   endtask

   task automatic chk_err(input string tag, input logic ov, input logic un);
`ifdef PARAM_FWFT_FIFO_ERRFLAG_EN
      chk({tag, "_overflow"}, 32'(overflow), 32'(ov));
      chk({tag, "_underflow"}, 32'(underflow), 32'(un));
`else
      if (ov !== un) begin end
`endif
   endtask

   initial begin
      nRst  = 1'b0;
      flush = 1'b0;
      data  = '0;
      wrreq = 1'b0;
      rdreq = 1'b0;
      tick();
      tick();
      chk_state("reset", 0, 8'h00);
      chk_err("reset", 1'b0, 1'b0);
      nRst = 1'b1;
      tick();

      // Single write then pop
      cyc(1'b1, 8'hA5, 1'b0, 1'b0);
      chk_state("wr_a5", 1, 8'hA5);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk_state("rd_a5", 0, 8'h00);

      // Read while empty is dropped
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk_state("rd_empty", 0, 8'h00);
      chk_err("rd_empty", 1'b0, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk_err("flush_clr", 1'b0, 1'b0);

      // Fill 0..3, checking level and almost flags at each step
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 8'(i), 1'b0, 1'b0);
         chk_state($sformatf("fill%0d", i), i + 1, 8'h00);
      end
      cyc(1'b1, 8'h99, 1'b0, 1'b0);
      chk_state("wr_full_drop", 4, 8'h00);
      chk_err("wr_full_drop", 1'b1, 1'b0);

      // Full with both requests: read wins, write dropped
      cyc(1'b1, 8'h77, 1'b1, 1'b0);
      chk_state("full_wr_rd", 3, 8'h01);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk_state("drain2", 2, 8'h02);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk_state("drain1", 1, 8'h03);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk_state("drain0", 0, 8'h00);

      // Empty with both requests: write wins, read dropped
      cyc(1'b1, 8'h5C, 1'b1, 1'b0);
      chk_state("empty_wr_rd", 1, 8'h5C);
      chk_err("empty_wr_rd", 1'b1, 1'b1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk_state("pop_5c", 0, 8'h00);

      // Streaming at level 2 across several pointer wraps
      cyc(1'b1, 8'h10, 1'b0, 1'b0);
      cyc(1'b1, 8'h11, 1'b0, 1'b0);
      chk_state("lvl2", 2, 8'h10);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 8'(8'h12 + i), 1'b1, 1'b0);
         chk_state($sformatf("stream%0d", i), 2, 8'(8'h11 + i));
      end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk_state("stream_tail", 1, 8'h1B);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk_state("stream_end", 0, 8'h00);

      // Flush at level 3 overrides a same-cycle write
      cyc(1'b1, 8'h21, 1'b0, 1'b0);
      cyc(1'b1, 8'h22, 1'b0, 1'b0);
      cyc(1'b1, 8'h23, 1'b0, 1'b0);
      chk_state("pre_flush", 3, 8'h21);
      cyc(1'b1, 8'h24, 1'b0, 1'b1);
      chk_state("flush", 0, 8'h00);
      chk_err("flush", 1'b0, 1'b0);

      // Build both error flags, come back to level 3, then reset with flush
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk_state("pre_reset", 3, 8'h31);
      chk_err("pre_reset", 1'b1, 1'b1);
      nRst = 1'b0;
      cyc(1'b1, 8'h55, 1'b0, 1'b1);
      chk_state("mid_reset", 0, 8'h00);
      chk_err("mid_reset", 1'b0, 1'b0);
      nRst = 1'b1;

      // First write after reset behaves as a write into an empty FIFO
      cyc(1'b1, 8'h42, 1'b0, 1'b0);
      chk_state("post_reset_wr", 1, 8'h42);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
